// File: rtl/multicycle_control_if.sv
// Memory handshake between the multicycle controller (master) and its memory port (slave).
interface multicycle_control_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic            mem_addr_sel;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr_sel,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr_sel,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32 subset controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing, PC,
// instruction register, retired counter and memory wait timeout.
module multicycle_control #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              CNT_W       = 32,
    parameter int              MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master mem,
    input  logic                 alu_zero_i,
    input  logic [XLEN-1:0]      branch_target_i,
    input  logic [XLEN-1:0]      alu_result_i,
    output logic [XLEN-1:0]      pc_o,
    output logic [31:0]          instr_o,
    output logic                 alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           alu_op_o,
    output logic                 reg_we_o,
    output logic [1:0]           wb_sel_o,
    output logic                 halted_o,
    output logic                 illegal_o,
    output logic                 bus_err_o,
    output logic [CNT_W-1:0]     retired_o
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_BAD
    } cls_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [WAIT_W-1:0] wait_q;
    logic              illegal_q, bus_err_q;
    cls_e              cls;
    logic              take_target;
    logic              req_c, we_c, addr_sel_c, reg_we_c;

    // The datapath forms the memory address from alu_result itself.
    logic unused_alu_result;
    assign unused_alu_result = ^alu_result_i;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cls = C_BAD;
        unique case (instr_q[6:0])
            OP_R:      cls = C_R;
            OP_I:      cls = C_I;
            OP_LOAD:   cls = C_LOAD;
            OP_STORE:  cls = C_STORE;
            OP_BRANCH: cls = (instr_q[14:13] == 2'b00) ? C_BRANCH : C_BAD;
            OP_JAL:    cls = C_JAL;
            OP_LUI:    cls = C_LUI;
            default:   cls = C_BAD;
        endcase
    end

    // funct3[0] selects BNE over BEQ.
    assign take_target = (cls == C_JAL) ||
                         (cls == C_BRANCH && (instr_q[12] ? !alu_zero_i : alu_zero_i));
    assign pc_d      = take_target ? branch_target_i : pc_q + XLEN'(4);
    assign retired_d = retired_q + 1'b1;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (mem.mem_ready) begin
                        instr_q <= mem.mem_rdata[31:0];
                        state_q <= S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (cls == C_BAD) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cls == C_LOAD || cls == C_STORE) begin
                        wait_q  <= '0;
                        state_q <= S_MEM;
                    end else if (cls == C_BRANCH) begin
                        pc_q      <= pc_d;
                        retired_q <= retired_d;
                        wait_q    <= '0;
                        state_q   <= S_FETCH;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.mem_ready) begin
                        if (cls == C_STORE) begin
                            pc_q      <= pc_d;
                            retired_q <= retired_d;
                            wait_q    <= '0;
                            state_q   <= S_FETCH;
                        end else begin
                            state_q <= S_WB;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WB: begin
                    pc_q      <= pc_d;
                    retired_q <= retired_d;
                    wait_q    <= '0;
                    state_q   <= S_FETCH;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    always_comb begin
        req_c       = 1'b0;
        we_c        = 1'b0;
        addr_sel_c  = 1'b0;
        reg_we_c    = 1'b0;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 2'b00;
        alu_op_o    = 2'b00;
        wb_sel_o    = 2'b00;
        unique case (state_q)
            S_FETCH: req_c = 1'b1;
            S_EXEC: begin
                unique case (cls)
                    C_R:              alu_op_o = 2'b10;
                    C_I:     begin alu_src_b_o = 2'b01; alu_op_o = 2'b10; end
                    C_LOAD, C_STORE:  alu_src_b_o = 2'b01;
                    C_BRANCH:         alu_op_o = 2'b01;
                    default:          ;
                endcase
            end
            S_MEM: begin
                req_c      = 1'b1;
                addr_sel_c = 1'b1;
                we_c       = (cls == C_STORE);
            end
            S_WB: begin
                reg_we_c = (instr_q[11:7] != 5'd0);
                unique case (cls)
                    C_LOAD:  wb_sel_o = 2'b01;
                    C_JAL:   wb_sel_o = 2'b10;
                    C_LUI:   wb_sel_o = 2'b11;
                    default: wb_sel_o = 2'b00;
                endcase
            end
            default: ;
        endcase
    end

    // Requests and register writes are gated by the live reset so they drop mid-access.
    assign mem.mem_req      = req_c && reset;
    assign mem.mem_we       = we_c;
    assign mem.mem_addr_sel = addr_sel_c;
    assign reg_we_o         = reg_we_c && reset;

    assign pc_o      = pc_q;
    assign instr_o   = instr_q;
    assign retired_o = retired_q;
    assign halted_o  = (state_q == S_HALT);
    assign illegal_o = illegal_q;
    assign bus_err_o = bus_err_q;
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value after reset.
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of the retired-instruction counter.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of cycles spent waiting for mem_ready.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk in 1 (rising-edge clock); reset in 1 (async active-low reset).
REQ-006 SHALL have ports mem_req out 1 (access request); mem_we out 1 (store); mem_addr_sel out 1 (0=pc, 1=alu_result).
REQ-007 SHALL have ports mem_ready in 1 (access complete this cycle); mem_rdata in XLEN (read data).
REQ-008 SHALL have ports alu_zero in 1; branch_target in XLEN (pc+imm from datapath adder); alu_result in XLEN.
REQ-009 SHALL have ports pc out XLEN; instr out 32 (instruction register).
REQ-010 SHALL have ports alu_src_a out 1 (0=rs1, 1=pc); alu_src_b out 2 (00=rs2, 01=imm, 10=4); alu_op out 2 (00=add, 01=sub, 10=funct-decoded).
REQ-011 SHALL have ports reg_we out 1; wb_sel out 2 (00=alu, 01=mem, 10=pc+4, 11=imm).
REQ-012 SHALL have ports halted out 1; illegal out 1; bus_err out 1; retired out CNT_W.

Function
REQ-013 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and HALT, with all outputs decoded from state and instr only.
REQ-014 In FETCH: mem_req=1, mem_we=0, mem_addr_sel=0; on mem_ready, instr<=mem_rdata[31:0] and the next state is DECODE; otherwise remain in FETCH.
REQ-015 DECODE SHALL last one cycle; the legal opcodes are 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL and 0110111 LUI.
REQ-016 In DECODE, any other opcode SHALL set illegal=1 and move to HALT.
REQ-017 EXEC SHALL last one cycle, with these controls: R: src_a=0, src_b=00, op=10; I-ALU: src_a=0, src_b=01, op=10; LOAD/STORE: src_a=0, src_b=01, op=00; BRANCH: src_a=0, src_b=00, op=01; JAL and LUI: no ALU use.
REQ-018 From EXEC, R, I-ALU, JAL and LUI SHALL go to WB; LOAD and STORE SHALL go to MEM; BRANCH SHALL go to FETCH.
REQ-019 BRANCH taken condition: funct3=000 (BEQ) and alu_zero=1, or funct3=001 (BNE) and alu_zero=0; any other funct3 SHALL be treated as illegal in DECODE.
REQ-020 In MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE only; on mem_ready, STORE goes to FETCH and LOAD goes to WB.
REQ-021 WB SHALL last one cycle with wb_sel = 00 for R/I-ALU, 01 for LOAD, 10 for JAL and 11 for LUI, then go to FETCH.
REQ-022 In WB, reg_we SHALL be 1 only if instr[11:7]!=0; reg_we SHALL be 0 in every other state.
REQ-023 PC update SHALL occur in exactly one cycle per instruction (the completion cycle): pc<=branch_target for taken BRANCH and JAL, otherwise pc<=pc+4, modulo 2^XLEN.
REQ-024 retired SHALL increment by 1 in each completion cycle, wrapping from 2^CNT_W-1 to 0.
REQ-025 Wait counter: cleared on entry to FETCH or MEM and incremented each cycle mem_ready=0; reaching MEM_TIMEOUT SHALL set bus_err=1 and move to HALT.
REQ-026 HALT SHALL be absorbing until reset: halted=1, mem_req=0, reg_we=0, and pc, instr and retired frozen.
REQ-027 mem_ready asserted outside FETCH/MEM SHALL be ignored.

Reset
REQ-028 While reset=0, asynchronously: state=FETCH, pc=RESET_PC, instr=0, retired=0, wait counter=0, illegal=0, bus_err=0, halted=0.
REQ-029 While reset=0, mem_req=0 and reg_we=0 regardless of state.
REQ-030 Reset asserted mid-access (FETCH/MEM) SHALL drop mem_req in the same cycle with no instr, pc or register update.
REQ-031 The first fetch from RESET_PC SHALL be requested on the first rising edge after reset deasserts.

Verification
REQ-032 ADDI x1,x0,5 with mem_ready on the 1st request cycle -> FETCH,DECODE,EXEC,WB = 4 cycles; reg_we=1 in WB; pc 0->4; retired=1.
REQ-033 LW x2,0(x1) with 3 wait cycles in FETCH and 2 in MEM -> mem_addr_sel 0 then 1; wb_sel=01; reg_we only in WB; pc=8.
REQ-034 BEQ, alu_zero=1, branch_target=0x40 -> pc=0x40, no reg_we; same BEQ with alu_zero=0 -> pc=pc+4.
REQ-035 ADD x0,x1,x2 -> WB visited with reg_we=0; illegal opcode 0x0000007F -> illegal=1, halted=1, pc frozen, mem_req stays 0.
REQ-036 mem_ready held 0 for MEM_TIMEOUT cycles in MEM -> bus_err=1 and HALT; reset pulse mid-MEM -> mem_req drops immediately and the fetch restarts at RESET_PC.
REQ-037 CNT_W=4, run 17 instructions -> retired wraps 15->0 and reads 1.
